// File: rtl/hub75_capture.sv
// hub75_capture
// Receive-side HUB75 engine. Oversamples the panel-side signals of an LED
// driver, rebuilds each latched scanline pair and replays it as pixel writes
// on a RAM-style write port with backpressure.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   hub_r/g/b [1:0]       colour bits, [0]=upper half row, [1]=lower half row
//   hub_addr [4:0]        row-pair address, sampled on the latch edge
//   hub_clk               shift clock, data captured on its rising edge
//   hub_latch             latch, row committed on its rising edge
//   wr_en / wr_ready      write handshake (see below)
//   wr_addr [AW-1:0]      row*MATRIX_WIDTH + col
//   wr_data [5:0]         {r[1],g[1],b[1],r[0],g[0],b[0]}
//   row_done, frame_done  last pixel of a row (of the last row) accepted
//   len_err               latch seen with a column count other than MATRIX_WIDTH
//   overrun               complete row latched while still draining; dropped
//   dbg_state             current FSM state (0=IDLE, 1=DRAIN)
//
// Handshake: a write transfers on every clk edge where wr_en && wr_ready.
// Once wr_en is raised, wr_addr/wr_data hold stable until the transfer
// happens; wr_en never drops without a transfer except on reset.
module hub75_capture #(
  parameter int MATRIX_WIDTH  = 64,
  parameter int MATRIX_HEIGHT = 64,
  parameter int AW            = $clog2(MATRIX_WIDTH * MATRIX_HEIGHT / 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    hub_r,
  input  logic [1:0]    hub_g,
  input  logic [1:0]    hub_b,
  input  logic [4:0]    hub_addr,
  input  logic          hub_clk,
  input  logic          hub_latch,
  output logic          wr_en,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [5:0]    wr_data,
  output logic          row_done,
  output logic          frame_done,
  output logic          len_err,
  output logic          overrun,
  output logic          dbg_state
);

  localparam int CW = $clog2(MATRIX_WIDTH);
  localparam int NW = $clog2(MATRIX_WIDTH + 2);
  localparam logic [NW-1:0] CNT_FULL = NW'(MATRIX_WIDTH);
  localparam logic [NW-1:0] CNT_SAT  = NW'(MATRIX_WIDTH + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [4:0]    LAST_ROW = 5'(MATRIX_HEIGHT / 2 - 1);
  localparam logic [AW-1:0] WIDTH_AW = AW'(MATRIX_WIDTH);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_d;

  // Two-flop synchronizers; stage 2 feeds both edge detect and data.
  logic       clk_s1, clk_s2, clk_prev;
  logic       lat_s1, lat_s2, lat_prev;
  logic [5:0] pix_s1, pix_s2;
  logic [4:0] addr_s1, addr_s2;

  logic [NW-1:0] col_cnt, cnt_shifted;
  logic [5:0]    line_buf      [MATRIX_WIDTH];
  logic [5:0]    line_buf_next [MATRIX_WIDTH];
  logic [5:0]    drain_buf     [MATRIX_WIDTH];
  logic [4:0]    drain_row;
  logic [CW-1:0] col;

  logic clk_rise, latch_rise, len_ok, commit, accept, last_accept;

  assign clk_rise   = clk_s2 & ~clk_prev;
  assign latch_rise = lat_s2 & ~lat_prev;

  // A shift in the same cycle as a latch is applied first, so the latch
  // judges the length (and copies the buffer) including that pixel.
  always_comb begin
    cnt_shifted = col_cnt;
    if (clk_rise && col_cnt != CNT_SAT) cnt_shifted = col_cnt + NW'(1);
  end

  // Newest pixel enters at the top; after MATRIX_WIDTH shifts the first
  // pixel sits in entry 0 and older pixels fall off the bottom.
  always_comb begin
    line_buf_next = line_buf;
    if (clk_rise) begin
      for (int i = 0; i < MATRIX_WIDTH - 1; i++) line_buf_next[i] = line_buf[i+1];
      line_buf_next[MATRIX_WIDTH-1] = pix_s2;
    end
  end

  assign len_ok      = (cnt_shifted == CNT_FULL);
  assign commit      = latch_rise && len_ok && (state_q == IDLE);
  assign accept      = (state_q == DRAIN) && wr_ready;
  assign last_accept = accept && (col == COL_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = DRAIN;
      DRAIN:   if (last_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      lat_s1    <= 1'b1;
      lat_s2    <= 1'b1;
      lat_prev  <= 1'b1;
      pix_s1    <= '0;
      pix_s2    <= '0;
      addr_s1   <= '0;
      addr_s2   <= '0;
      col_cnt   <= '0;
      drain_row <= '0;
      col       <= '0;
      len_err   <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
        line_buf[i]  <= '0;
        drain_buf[i] <= '0;
      end
    end else begin
      clk_s1   <= hub_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      lat_s1   <= hub_latch;
      lat_s2   <= lat_s1;
      lat_prev <= lat_s2;
      pix_s1   <= {hub_r[1], hub_g[1], hub_b[1], hub_r[0], hub_g[0], hub_b[0]};
      pix_s2   <= pix_s1;
      addr_s1  <= hub_addr;
      addr_s2  <= addr_s1;

      line_buf <= line_buf_next;
      col_cnt  <= latch_rise ? '0 : cnt_shifted;
      len_err  <= latch_rise && !len_ok;
      overrun  <= latch_rise && len_ok && (state_q == DRAIN);

      if (commit) begin
        drain_buf <= line_buf_next;
        drain_row <= addr_s2;
        col       <= '0;
      end else if (accept) begin
        col <= last_accept ? '0 : col + CW'(1);
      end
    end
  end

  // Outputs come straight from drain registers; the done pulses also need
  // wr_ready so they coincide with the final accepted write.
  assign wr_en      = (state_q == DRAIN);
  assign wr_addr    = wr_en ? (AW'(drain_row) * WIDTH_AW + AW'(col)) : '0;
  assign wr_data    = wr_en ? drain_buf[col] : '0;
  assign row_done   = last_accept;
  assign frame_done = last_accept && (drain_row == LAST_ROW);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hub75_capture.sv
module tb_hub75_capture;

  localparam int W  = 64;
  localparam int AW = 11;
  localparam int EW = AW + 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    hub_r, hub_g, hub_b;
  logic [4:0]    hub_addr;
  logic          hub_clk, hub_latch;
  logic          wr_en;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;
  logic          row_done, frame_done, len_err, overrun, dbg_state;

  hub75_capture #(.MATRIX_WIDTH(64), .MATRIX_HEIGHT(64)) dut (
    .clk(clk), .rst(rst),
    .hub_r(hub_r), .hub_g(hub_g), .hub_b(hub_b), .hub_addr(hub_addr),
    .hub_clk(hub_clk), .hub_latch(hub_latch),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .row_done(row_done), .frame_done(frame_done),
    .len_err(len_err), .overrun(overrun), .dbg_state(dbg_state)
  );

  // scoreboard: {frame_done, row_done, addr, data} per expected write
  logic [EW-1:0] exp_q[$];
  logic [5:0]    pix_q[$];

  int vectors = 0;
  int errors  = 0;
  int accept_cnt = 0;
  int wen_cycles = 0;
  int le_seen = 0, ov_seen = 0, le_exp = 0, ov_exp = 0;
  int rmode = 0;  // 0: ready=1, 1: toggle, 2: ready=0, 3: random

  // inputs change 2 time units after the active edge; monitor samples at negedge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #2;
    case (rmode)
      0: wr_ready = 1'b1;
      1: wr_ready = ~wr_ready;
      2: wr_ready = 1'b0;
      default: wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor
  logic          stall_prev = 1'b0;
  logic          rst_prev   = 1'b0;
  logic [AW-1:0] addr_prev;
  logic [5:0]    data_prev;

  always @(negedge clk) begin
    logic [EW-1:0] e, got;
    got = {frame_done, row_done, wr_addr, wr_data};
    if (wr_en) wen_cycles++;
    if (len_err) le_seen++;
    if (overrun) ov_seen++;
    if (wr_en && wr_ready) begin
      accept_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL write: got fd=%b rd=%b addr=%0d data=%h, required fd=%b rd=%b addr=%0d data=%h",
                   got[EW-1], got[EW-2], got[AW+5:6], got[5:0], e[EW-1], e[EW-2], e[AW+5:6], e[5:0]);
        end
      end
    end else begin
      vectors++;
      if (row_done || frame_done) begin
        errors++;
        $display("FAIL stray_done: got rd=%b fd=%b without accepted write, required 0 0", row_done, frame_done);
      end
    end
    if (stall_prev && !rst_prev) begin
      vectors++;
      if (!wr_en || wr_addr !== addr_prev || wr_data !== data_prev) begin
        errors++;
        $display("FAIL stall_hold: got en=%b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                 wr_en, wr_addr, wr_data, addr_prev, data_prev);
      end
    end
    stall_prev = wr_en && !wr_ready;
    rst_prev   = rst;
    addr_prev  = wr_addr;
    data_prev  = wr_data;
  end

  // driver tasks
  task automatic send_pixel(input logic [5:0] d);
    hub_r = {d[5], d[2]};
    hub_g = {d[4], d[1]};
    hub_b = {d[3], d[0]};
    hub_clk = 1'b0;
    repeat (2) tick();
    hub_clk = 1'b1;
    repeat (2) tick();
    hub_clk = 1'b0;
    pix_q.push_back(d);
  endtask

  task automatic send_latch(input logic [4:0] a);
    int n, xle, xov, le, ov;
    logic [AW-1:0] ad;
    logic last;
    n   = pix_q.size();
    xle = (n != W) ? 1 : 0;
    xov = (xle == 0 && exp_q.size() != 0) ? 1 : 0;
    if (xle == 0 && xov == 0) begin
      for (int i = 0; i < W; i++) begin
        ad   = AW'((int'(a) * W + i) % (1 << AW));
        last = (i == W - 1);
        exp_q.push_back({last && (a == 5'd31), last, ad, pix_q[i]});
      end
    end
    pix_q.delete();
    le_exp += xle;
    ov_exp += xov;
    hub_addr = a;
    repeat (2) tick();
    hub_latch = 1'b1;
    le = 0;
    ov = 0;
    repeat (6) begin
      @(negedge clk);
      le += int'(len_err);
      ov += int'(overrun);
    end
    tick();
    hub_latch = 1'b0;
    repeat (2) tick();
    vectors++;
    if (le != xle || ov != ox_fix(xov)) begin
      errors++;
      $display("FAIL latch_pulses row=%0d len=%0d: got len_err=%0d overrun=%0d, required %0d %0d",
               a, n, le, ov, xle, xov);
    end
  endtask

  function automatic int ox_fix(input int v);
    return v;
  endfunction

  task automatic send_row(input logic [4:0] a, input int n, input bit rnd);
    for (int i = 0; i < n; i++) send_pixel(rnd ? 6'($urandom_range(0, 63)) : 6'(i));
    send_latch(a);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !wr_en) break;
    end
    vectors++;
    if (i >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d writes pending, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic wait_accepts(input int target);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (accept_cnt >= target) break;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (accept_cnt < target) begin
      errors++;
      $display("FAIL accept_timeout: got %0d accepts, required %0d", accept_cnt, target);
    end
  endtask

  initial begin
    int w0, base;
    rst = 1'b1;
    hub_clk = 1'b1;
    hub_latch = 1'b1;
    hub_r = '0; hub_g = '0; hub_b = '0;
    hub_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset released with shift clock and latch high: nothing may happen
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (wr_en || len_err || overrun || row_done || frame_done || dbg_state) begin
        errors++;
        $display("FAIL idle_after_reset: got en=%b le=%b ov=%b rd=%b fd=%b st=%b, required all 0",
                 wr_en, len_err, overrun, row_done, frame_done, dbg_state);
      end
    end
    tick();
    hub_clk = 1'b0;
    hub_latch = 1'b0;
    repeat (4) tick();

    // full row, pixel i = i, row 5, ready held high
    rmode = 0;
    w0 = wen_cycles;
    send_row(5'd5, W, 1'b0);
    wait_drain();
    vectors++;
    if (wen_cycles - w0 != W) begin
      errors++;
      $display("FAIL drain_length: got %0d wr_en cycles, required %0d", wen_cycles - w0, W);
    end

    // wrong lengths
    send_row(5'($urandom_range(0, 31)), W - 1, 1'b1);
    wait_drain();
    send_row(5'($urandom_range(0, 31)), W + 1, 1'b1);
    wait_drain();

    // last row with toggling backpressure
    rmode = 1;
    send_row(5'd31, W, 1'b1);
    wait_drain();

    // overrun: row 2 stalled, row 3 latched meanwhile and dropped
    rmode = 2;
    send_row(5'd2, W, 1'b1);
    send_row(5'd3, W, 1'b1);
    rmode = 0;
    wait_drain();

    // random rows, random backpressure, occasional short row
    for (int r = 0; r < 6; r++) begin
      rmode = 3;
      send_row(5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0) ? W - 1 : W, 1'b1);
      wait_drain();
    end

    // reset in the middle of a drain
    rmode = 1;
    base = accept_cnt;
    send_row(5'($urandom_range(0, 30)), W, 1'b1);
    wait_accepts(base + 10);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (wr_en) begin
        errors++;
        $display("FAIL reset_mid_drain: got wr_en=%b, required 0", wr_en);
      end
    end
    tick();
    exp_q.delete();
    pix_q.delete();
    rst = 1'b0;
    repeat (4) tick();
    w0 = accept_cnt;
    repeat (20) tick();
    vectors++;
    if (accept_cnt != w0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d writes, required 0", accept_cnt - w0);
    end

    // normal operation after reset
    rmode = 0;
    send_row(5'($urandom_range(0, 31)), W, 1'b1);
    wait_drain();

    repeat (5) tick();
    vectors++;
    if (le_seen != le_exp || ov_seen != ov_exp) begin
      errors++;
      $display("FAIL pulse_totals: got len_err=%0d overrun=%0d, required %0d %0d",
               le_seen, ov_seen, le_exp, ov_exp);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d writes never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
